sample_sequencer: RTL and testbench

Upstream feeder for the interpolator stage. It steps through a waveform sample memory, which is synchronous with 1-cycle read latency. Once per output period of N = 10**Mode Fg_CLK cycles, it presents a segment to the interpolator:
- out2 = start sample
- out1 = end sample
- Enable = 1-cycle load pulse

It keeps one sample prefetched so that both segment endpoints change together on the same edge as Enable.

---
 rtl/sample_sequencer_pkg.sv | 41 ++++
 rtl/sample_sequencer_period_counter.sv | 32 +++
 rtl/sample_sequencer.sv | 134 +++++++++++++
 tb/tb_sample_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sample_sequencer_pkg.sv
// Shared definitions for the sample sequencer.
//   state_t     : sequencer FSM states
//   MODE_MIN/MAX: accepted range of the period-select exponent
//   CNT_W       : width of the period down-counter
//   period_n()  : constant 10**k lookup, k = 0..6
//   clamp_mode(): folds a raw 4-bit Mode into [MODE_MIN, MODE_MAX]
package sample_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int unsigned MODE_MIN = 1;
  localparam int unsigned MODE_MAX = 6;
  localparam int          CNT_W    = 20;

  function automatic logic [CNT_W-1:0] period_n(input logic [2:0] k);
    logic [CNT_W-1:0] n;
    case (k)
      3'd0:    n = 20'd1;
      3'd1:    n = 20'd10;
      3'd2:    n = 20'd100;
      3'd3:    n = 20'd1000;
      3'd4:    n = 20'd10000;
      3'd5:    n = 20'd100000;
      default: n = 20'd1000000;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] clamp_mode(input logic [3:0] m);
    logic [2:0] k;
    if (m < 4'(MODE_MIN))      k = 3'(MODE_MIN);
    else if (m > 4'(MODE_MAX)) k = 3'(MODE_MAX);
    else                       k = m[2:0];
    return k;
  endfunction

endpackage

// File: rtl/sample_sequencer_period_counter.sv
// Loadable period down-counter.
//   clk, rst : clock, async active-high reset
//   load     : reload with period_n(mode) - 1 (wins over en)
//   en       : decrement while nonzero
//   mode     : clamped period exponent used on load
//   tc       : terminal count, high while the count is zero
module period_counter
  import sample_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [2:0] mode,
  output logic       tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= period_n(mode) - 20'd1;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 20'd1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sample_sequencer.sv
// Sample sequencer: walks a synchronous (1-cycle latency) sample memory and
// hands the interpolator one segment (start/end sample) every 10**Mode cycles.
//   Fg_CLK, RESET : clock, async active-high reset
//   Run           : level, 1 = sequence samples
//   Mode          : period exponent (clamped to 1..6)
//   Length        : last valid memory address
//   mem_rd/addr   : read request;  mem_data returns one cycle later
//   out2/out1     : segment start/end sample
//   Enable        : 1-cycle pulse when a new segment is presented
//   Busy          : high outside IDLE
//
// state | meaning
// IDLE  | stopped, outputs hold, read pointer parked at 0
// FILL  | three priming reads shifting through prefetch -> out1 -> out2
// RUN   | counting the period; at terminal count advance the segment
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              Fg_CLK,
  input  logic              RESET,
  input  logic              Run,
  input  logic [3:0]        Mode,
  input  logic [ADDR_W-1:0] Length,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              Enable,
  output logic              Busy
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] rd_ptr, ptr_next;
  logic [1:0]        fill_cnt;
  logic              rd_q, capture, load, enable_d, tc, cnt_en, shift_out;
  logic [DATA_W-1:0] prefetch;
  logic [2:0]        mode_q, mode_q_d;

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_rd     = 1'b0;
    load       = 1'b0;
    enable_d   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Run) next_state = ST_FILL;
      end
      ST_FILL: begin
        if (!Run) begin
          next_state = ST_IDLE;
        end else if (fill_cnt != 2'd3) begin
          mem_rd = 1'b1;
        end else begin
          // third word is being captured this cycle; segment is complete
          next_state = ST_RUN;
          load       = 1'b1;
          enable_d   = 1'b1;
        end
      end
      ST_RUN: begin
        if (!Run) begin
          next_state = ST_IDLE;
        end else if (tc) begin
          mem_rd   = 1'b1;
          load     = 1'b1;
          enable_d = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Data returning after Run drops is dropped, so outputs hold in IDLE.
  assign capture   = rd_q & Run & (state != ST_IDLE);
  assign shift_out = ((state == ST_FILL) && capture) || ((state == ST_RUN) && load);
  // The counter reloads from the mode being committed on this edge, so a
  // new Mode governs the period that starts at this boundary.
  assign mode_q_d  = load ? clamp_mode(Mode) : mode_q;
  // >= rather than == so a Length shrunk below rd_ptr wraps immediately.
  assign ptr_next  = (rd_ptr >= Length) ? '0 : rd_ptr + ADDR_W'(1);
  assign cnt_en    = (state == ST_RUN);

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr   <= '0;
      fill_cnt <= '0;
      rd_q     <= 1'b0;
      prefetch <= '0;
      out1     <= '0;
      out2     <= '0;
      Enable   <= 1'b0;
      mode_q   <= 3'(MODE_MIN);
    end else begin
      rd_q   <= mem_rd;
      Enable <= enable_d;
      mode_q <= mode_q_d;

      if (state == ST_IDLE) rd_ptr <= '0;
      else if (mem_rd)      rd_ptr <= ptr_next;

      if (state != ST_FILL) fill_cnt <= '0;
      else if (mem_rd)      fill_cnt <= fill_cnt + 2'd1;

      if (capture) prefetch <= mem_data;

      if (shift_out) begin
        out2 <= out1;
        out1 <= prefetch;
      end
    end
  end

  assign mem_addr = rd_ptr;
  assign Busy     = (state != ST_IDLE);

  period_counter u_period (
    .clk  (Fg_CLK),
    .rst  (RESET),
    .load (load),
    .en   (cnt_en),
    .mode (mode_q_d),
    .tc   (tc)
  );

endmodule

// File: tb/tb_sample_sequencer.sv
// Self-checking bench for sample_sequencer: behavioural memory plus a
// segment-level reference model (address walk, 10**mode gaps).
module tb_sample_sequencer;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              run = 1'b0;
  logic [3:0]        mode = 4'd1;
  logic [ADDR_W-1:0] length = 10'd7;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] out1, out2;
  logic              enable, busy;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  int n_checks = 0;
  int n_pass   = 0;

  sample_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Fg_CLK   (clk),
    .RESET    (rst),
    .Run      (run),
    .Mode     (mode),
    .Length   (length),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .out1     (out1),
    .out2     (out2),
    .Enable   (enable),
    .Busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int model_period(input logic [3:0] m);
    int k, n;
    k = (m < 4'd1) ? 1 : ((m > 4'd6) ? 6 : int'(m));
    n = 1;
    for (int i = 0; i < k; i++) n = n * 10;
    return n;
  endfunction

  function automatic int model_next(input int a, input int len);
    return (a >= len) ? 0 : a + 1;
  endfunction

  // Caller raises run at a negedge, then calls. Watches n_en Enables.
  // After enable number chg_at has been seen, chg_dly cycles later, Mode
  // becomes chg_mode (mid-period).
  task automatic run_check(input int n_en, input int chg_at, input int chg_dly,
                           input logic [3:0] chg_mode);
    int addr, nxt, gap, exp_gap, seen, budget;
    addr = 0; seen = 0; gap = 0; budget = 0;
    exp_gap = 5;  // enter FILL, three reads, one cycle after the last return
    while (seen < n_en && budget < 20000) begin
      @(negedge clk);
      gap++; budget++;
      if (length == '0 && mem_rd) check_val("len0_addr", mem_addr, 0);
      if (enable) begin
        nxt = model_next(addr, int'(length));
        check_val("gap", gap, exp_gap);
        check_val("out2", out2, mem[addr]);
        check_val("out1", out1, mem[nxt]);
        check_val("busy_run", busy, 1);
        exp_gap = model_period(mode);
        addr = nxt; gap = 0; seen++;
      end
      if (seen == chg_at && gap == chg_dly) mode = chg_mode;
    end
    if (seen < n_en) check_val("enable_timeout", seen, n_en);
  endtask

  task automatic stop_and_check(input string tag);
    run = 1'b0;
    @(negedge clk);
    check_val({tag, "_enable"}, enable, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int en_seen, n_en, dly;
    for (int k = 0; k < DEPTH; k++) mem[k] = k * 32'h40000;

    #1 rst = 1'b1;
    #1;
    check_val("rst_out1", out1, 0);
    check_val("rst_out2", out2, 0);
    check_val("rst_enable", enable, 0);
    check_val("rst_mem_rd", mem_rd, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_addr", mem_addr, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_busy", busy, 0);

    // basic walk with wrap 7 -> 0
    length = 10'd7; mode = 4'd1; run = 1'b1;
    run_check(10, -1, 0, 4'd1);
    // drop Run 3 cycles after an Enable, then restart from address 0
    repeat (3) @(negedge clk);
    stop_and_check("drop");
    run = 1'b1;
    run_check(3, -1, 0, 4'd1);
    stop_and_check("stop1");

    // mode 1 -> 2 mid-period
    mode = 4'd1; run = 1'b1;
    run_check(5, 2, 4, 4'd2);
    stop_and_check("stop2");

    // clamping: mode 0 acts as 1, mode 9 acts as 6
    mode = 4'd0; run = 1'b1;
    run_check(4, 3, 3, 4'd9);
    check_val("clamp_cnt_load", dut.u_period.cnt, model_period(4'd9) - 1);
    en_seen = 0;
    repeat (4000) begin
      @(negedge clk);
      if (enable) en_seen++;
    end
    check_val("clamp_quiet", en_seen, 0);
    check_val("clamp_cnt_run", dut.u_period.cnt, model_period(4'd9) - 1 - 4000);
    stop_and_check("stop3");

    // Length = 0: every read at address 0, flat segments
    length = '0; mode = 4'd1; run = 1'b1;
    run_check(5, -1, 0, 4'd1);
    stop_and_check("stop4");

    // asynchronous reset mid-RUN
    length = 10'd7; mode = 4'd1; run = 1'b1;
    run_check(4, -1, 0, 4'd1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_out1", out1, 0);
    check_val("arst_out2", out2, 0);
    check_val("arst_enable", enable, 0);
    check_val("arst_mem_rd", mem_rd, 0);
    check_val("arst_busy", busy, 0);
    run = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    en_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || mem_rd || enable) en_seen++;
    end
    check_val("post_rst_quiet", en_seen, 0);
    // Run held high through reset: leaves IDLE on first edge after release
    rst = 1'b1; run = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    run_check(3, -1, 0, 4'd1);
    stop_and_check("stop6");

    // randomized segments, lengths, mode changes and Run drops
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      length = ADDR_W'($urandom_range(0, 9));
      mode   = 4'($urandom_range(0, 2));
      n_en   = $urandom_range(3, 7);
      run    = 1'b1;
      run_check(n_en, $urandom_range(0, n_en - 1), $urandom_range(1, 8),
                4'($urandom_range(0, 2)));
      dly = $urandom_range(1, 9);
      repeat (dly) @(negedge clk);
      stop_and_check("rnd_stop");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
